// File: rtl/gte_bridge_pkg.sv
// Shared types for the CPU-side GTE COP2 bridge: op codes, FSM states and the
// E_REG register-ID layout ({bank, reg}).
package gte_bridge_pkg;

  typedef enum logic [2:0] {
    OP_MTC2 = 3'd0,
    OP_CTC2 = 3'd1,
    OP_MFC2 = 3'd2,
    OP_CFC2 = 3'd3,
    OP_CMD  = 3'd4
  } cpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STALL = 3'd1,
    ST_WRITE = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_ISSUE = 3'd5
  } state_e;

  // E_REG bank select: 0 = data bank, 1 = control bank
  localparam int E_REG_BANK_BIT = 5;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > 3'(OP_CMD);
  endfunction

  function automatic logic op_ctrl_bank(input logic [2:0] op);
    return (op == 3'(OP_CTC2)) || (op == 3'(OP_CFC2));
  endfunction

  function automatic logic [5:0] e_reg(input logic ctrl, input logic [4:0] num);
    logic [5:0] id;
    id = {1'b0, num};
    id[E_REG_BANK_BIT] = ctrl;
    return id;
  endfunction

  function automatic state_e op_state(input logic [2:0] op);
    state_e st;
    case (op)
      3'(OP_MTC2), 3'(OP_CTC2): st = ST_WRITE;
      3'(OP_MFC2), 3'(OP_CFC2): st = ST_RADDR;
      3'(OP_CMD):               st = ST_ISSUE;
      default:                  st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/gte_cop2_bridge.sv
// COP2 request bridge: writes/commands act in A+1, reads return data in A+3, plus one cycle per stall.
// Only accepts in IDLE (o_cpuReady); stalls while the engine reports i_executing.
module gte_cop2_bridge
  import gte_bridge_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic        i_cpuValid,
  output logic        o_cpuReady,
  input  logic [2:0]  i_cpuOp,
  input  logic [4:0]  i_cpuReg,
  input  logic [31:0] i_cpuData,
  input  logic [24:0] i_cpuCmd,
  output logic        o_cpuRdValid,
  output logic [31:0] o_cpuRdData,
  output logic        o_cpuErr,
  output logic        o_cpuBusy,
  output logic [5:0]  o_regID,
  output logic        o_writeReg,
  output logic [31:0] o_dataOut,
  input  logic [31:0] i_gteData,
  output logic [24:0] o_instruction,
  output logic        o_run,
  input  logic        i_executing,
  output logic [15:0] o_stallCycles
);

  state_e      state, state_nxt;
  logic        accept;
  logic        launch;
  logic [2:0]  op_q;
  logic [4:0]  reg_q;
  logic [31:0] data_q;
  logic [24:0] cmd_q;
  logic [2:0]  src_op;
  logic [4:0]  src_reg;
  logic [31:0] src_data;
  logic [24:0] src_cmd;

  assign accept = (state == ST_IDLE) && i_cpuValid;

  // Op fields come straight from the CPU on a no-stall accept, else from the latch.
  assign src_op   = (state == ST_IDLE) ? i_cpuOp   : op_q;
  assign src_reg  = (state == ST_IDLE) ? i_cpuReg  : reg_q;
  assign src_data = (state == ST_IDLE) ? i_cpuData : data_q;
  assign src_cmd  = (state == ST_IDLE) ? i_cpuCmd  : cmd_q;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_cpuValid && !op_reserved(i_cpuOp)) begin
          if (i_executing) begin
            state_nxt = ST_STALL;
          end else begin
            state_nxt = op_state(i_cpuOp);
            launch    = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (!i_executing) begin
          state_nxt = op_state(op_q);
          launch    = 1'b1;
        end
      end
      ST_RADDR: state_nxt = ST_RDATA;
      ST_WRITE, ST_RDATA, ST_ISSUE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      op_q   <= '0;
      reg_q  <= '0;
      data_q <= '0;
      cmd_q  <= '0;
    end else if (accept) begin
      op_q   <= i_cpuOp;
      reg_q  <= i_cpuReg;
      data_q <= i_cpuData;
      cmd_q  <= i_cpuCmd;
    end
  end

  // Engine-facing fields only change when an op state is entered; they hold otherwise.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      o_regID       <= '0;
      o_dataOut     <= '0;
      o_instruction <= '0;
    end else if (launch) begin
      if (src_op != 3'(OP_CMD)) begin
        o_regID <= e_reg(op_ctrl_bank(src_op), src_reg);
      end
      if (op_state(src_op) == ST_WRITE) begin
        o_dataOut <= src_data;
      end
      if (src_op == 3'(OP_CMD)) begin
        o_instruction <= src_cmd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      o_cpuErr      <= 1'b0;
      o_cpuRdValid  <= 1'b0;
      o_cpuRdData   <= '0;
      o_stallCycles <= '0;
    end else begin
      o_cpuErr     <= accept && op_reserved(i_cpuOp);
      o_cpuRdValid <= (state == ST_RDATA);
      if (state == ST_RDATA) begin
        o_cpuRdData <= i_gteData;
      end
      if ((state == ST_STALL) && (o_stallCycles != 16'hFFFF)) begin
        o_stallCycles <= o_stallCycles + 16'd1;
      end
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign o_cpuReady = (state == ST_IDLE);
  assign o_writeReg = (state == ST_WRITE);
  assign o_run      = (state == ST_ISSUE);
  assign o_cpuBusy  = (state != ST_IDLE) || i_executing;

endmodule

// File: tb/tb_gte_cop2_bridge.sv
// Directed + randomized bench for gte_cop2_bridge with a transaction-level reference model.
module tb_gte_cop2_bridge;

  logic        i_clk = 1'b0;
  logic        i_nRst = 1'b0;
  logic        i_cpuValid = 1'b0;
  logic        o_cpuReady;
  logic [2:0]  i_cpuOp = '0;
  logic [4:0]  i_cpuReg = '0;
  logic [31:0] i_cpuData = '0;
  logic [24:0] i_cpuCmd = '0;
  logic        o_cpuRdValid;
  logic [31:0] o_cpuRdData;
  logic        o_cpuErr;
  logic        o_cpuBusy;
  logic [5:0]  o_regID;
  logic        o_writeReg;
  logic [31:0] o_dataOut;
  logic [31:0] i_gteData = '0;
  logic [24:0] o_instruction;
  logic        o_run;
  logic        i_executing = 1'b0;
  logic [15:0] o_stallCycles;

  int n_cmp = 0;
  int n_fail = 0;
  int stall_exp = 0;
  logic [31:0] eng_rf [64];
  logic [31:0] ref_rf [64];

  gte_cop2_bridge dut (
    .i_clk(i_clk), .i_nRst(i_nRst), .i_cpuValid(i_cpuValid), .o_cpuReady(o_cpuReady),
    .i_cpuOp(i_cpuOp), .i_cpuReg(i_cpuReg), .i_cpuData(i_cpuData), .i_cpuCmd(i_cpuCmd),
    .o_cpuRdValid(o_cpuRdValid), .o_cpuRdData(o_cpuRdData), .o_cpuErr(o_cpuErr),
    .o_cpuBusy(o_cpuBusy), .o_regID(o_regID), .o_writeReg(o_writeReg), .o_dataOut(o_dataOut),
    .i_gteData(i_gteData), .o_instruction(o_instruction), .o_run(o_run),
    .i_executing(i_executing), .o_stallCycles(o_stallCycles)
  );

  always #5 i_clk = ~i_clk;

  // Engine register file: writes land on the strobe, reads return one cycle after o_regID.
  always @(posedge i_clk) begin
    if (o_writeReg) eng_rf[o_regID] <= o_dataOut;
    i_gteData <= eng_rf[o_regID];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU request; n = number of cycles i_executing is high starting with the request cycle.
  task automatic do_req(input logic [2:0] op, input logic [4:0] rg, input logic [31:0] dat,
                        input logic [24:0] cmd, input int n);
    logic rsv, wr, rd, cm;
    logic [5:0] rid;
    logic [31:0] exp_rd;
    int op_c, last;
    rsv = (op > 3'd4);
    wr  = (op == 3'd0) || (op == 3'd1);
    rd  = (op == 3'd2) || (op == 3'd3);
    cm  = (op == 3'd4);
    rid = {(op == 3'd1) || (op == 3'd3), rg};
    op_c = n + 1;
    last = rsv ? 2 : (rd ? n + 3 : n + 1);
    exp_rd = '0;

    @(posedge i_clk); #1;
    i_cpuValid = 1'b1; i_cpuOp = op; i_cpuReg = rg; i_cpuData = dat; i_cpuCmd = cmd;
    i_executing = (n > 0);
    @(negedge i_clk);
    chk("ready_at_request", o_cpuReady, 1);
    @(posedge i_clk); #1;
    i_cpuValid = 1'b0;

    if (!rsv) stall_exp = (stall_exp + n > 65535) ? 65535 : stall_exp + n;
    if (rd) exp_rd = ref_rf[rid];
    if (wr) ref_rf[rid] = dat;

    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin
        @(posedge i_clk); #1;
      end
      i_executing = (c < n);
      @(negedge i_clk);
      chk("write_strobe", o_writeReg, wr && (c == op_c));
      chk("run_strobe", o_run, cm && (c == op_c));
      chk("err_pulse", o_cpuErr, rsv && (c == 1));
      chk("rd_valid", o_cpuRdValid, rd && (c == n + 3));
      if (c <= n) chk("busy_in_stall", o_cpuBusy, 1);
      if (!rsv && (c == op_c)) begin
        if (wr || rd) chk("reg_id", o_regID, rid);
        if (wr) chk("data_out", o_dataOut, dat);
        if (cm) chk("instruction", o_instruction, cmd);
      end
      if (rd && (c == n + 2)) chk("reg_id_held", o_regID, rid);
      if (rd && (c == n + 3)) chk("rd_data", o_cpuRdData, exp_rd);
    end
    chk("stall_cycles", o_stallCycles, stall_exp);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      eng_rf[i] = v;
      ref_rf[i] = v;
    end
    eng_rf[63] = 32'hDEAD_BEEF;
    ref_rf[63] = 32'hDEAD_BEEF;

    #12;
    chk("rst_ready", o_cpuReady, 1);
    chk("rst_write", o_writeReg, 0);
    chk("rst_run", o_run, 0);
    chk("rst_rdvalid", o_cpuRdValid, 0);
    chk("rst_rddata", o_cpuRdData, 0);
    chk("rst_err", o_cpuErr, 0);
    chk("rst_busy", o_cpuBusy, 0);
    chk("rst_regid", o_regID, 0);
    chk("rst_stall", o_stallCycles, 0);
    @(negedge i_clk);
    i_nRst = 1'b1;

    do_req(3'd0, 5'd7, 32'h1234_5678, 25'h0, 0);
    do_req(3'd3, 5'd31, 32'h0, 25'h0, 0);
    do_req(3'd6, 5'd4, 32'hFFFF_FFFF, 25'h1FF_FFFF, 0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      int n;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      n = (op > 3'd4 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
      do_req(op, 5'($urandom), $urandom, 25'($urandom), n);
    end

    // Asynchronous reset in the middle of an ISSUE cycle
    @(posedge i_clk); #1;
    i_cpuValid = 1'b1; i_cpuOp = 3'd4; i_cpuCmd = 25'h0AB_CDEF;
    @(posedge i_clk); #1;
    i_cpuValid = 1'b0;
    chk("run_before_reset", o_run, 1);
    #2;
    i_nRst = 1'b0;
    #1;
    chk("run_async_drop", o_run, 0);
    chk("ready_after_reset", o_cpuReady, 1);
    chk("stall_after_reset", o_stallCycles, 0);
    chk("instr_after_reset", o_instruction, 0);
    stall_exp = 0;
    @(negedge i_clk);
    i_nRst = 1'b1;

    do_req(3'd4, 5'd0, 32'h0, 25'h000_0012, 0);
    do_req(3'd2, 5'd9, 32'h0, 25'h0, 10);
    chk("stall_after_cmd_read", o_stallCycles, 10);

    do_req(3'd1, 5'd3, $urandom, 25'h0, 70000);
    chk("stall_saturated", o_stallCycles, 16'hFFFF);
    do_req(3'd0, 5'd1, $urandom, 25'h0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
